// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN core and its configuration loader: geometry,
// framing constants, loader state encoding and the power-on weight set.
package bnn_pkg;

   localparam int NUM_NEURONS   = 4;
   localparam int NUM_WEIGHTS   = 6;
   localparam int THR_W         = 3;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam int PAYLOAD_BYTES = 2 * NUM_NEURONS;
   localparam int CNT_W         = $clog2(PAYLOAD_BYTES + 1);

   // Neuron n occupies [n*NUM_WEIGHTS +: NUM_WEIGHTS]; neuron 0 is the LSB field.
   localparam logic [NUM_NEURONS*NUM_WEIGHTS-1:0] DEFAULT_WEIGHTS =
      24'b110011_001100_000111_111000;
   localparam logic [NUM_NEURONS*THR_W-1:0] DEFAULT_THRESHOLDS = 12'h492;

   typedef enum logic [1:0] {
      IDLE,
      PAYLOAD,
      CHECK,
      COMMIT
   } cfg_state_e;

   // A payload byte is well-formed when every bit above its field is zero.
   function automatic logic byte_fmt_ok(input logic [7:0] b, input logic is_thr);
      if (is_thr)
         return (b[7:THR_W] == '0);
      else
         return (b[7:NUM_WEIGHTS] == '0);
   endfunction

endpackage

// File: rtl/bnn_cfg_shadow.sv
// Shadow register bank filled slot by slot during a frame, and the active
// configuration it is copied into as a whole on commit.
module bnn_cfg_shadow
   import bnn_pkg::*;
(
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               wr_en_i,
   input  logic [CNT_W-1:0]                   wr_slot_i,
   input  logic [NUM_WEIGHTS-1:0]             wr_data_i,
   input  logic                               commit_i,
   output logic [NUM_NEURONS*NUM_WEIGHTS-1:0] weights_o,
   output logic [NUM_NEURONS*THR_W-1:0]       thresholds_o
);

   logic [NUM_NEURONS*NUM_WEIGHTS-1:0] shw_q;
   logic [NUM_NEURONS*THR_W-1:0]       sht_q;
   logic [NUM_NEURONS*NUM_WEIGHTS-1:0] actw_q;
   logic [NUM_NEURONS*THR_W-1:0]       actt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shw_q  <= '0;
         sht_q  <= '0;
         actw_q <= DEFAULT_WEIGHTS;
         actt_q <= DEFAULT_THRESHOLDS;
      end else begin
         if (commit_i) begin
            actw_q <= shw_q;
            actt_q <= sht_q;
         end
         // Even slots carry weights, odd slots thresholds, neuron = slot >> 1.
         if (wr_en_i) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
               if (wr_slot_i == CNT_W'(2 * n))
                  shw_q[n*NUM_WEIGHTS +: NUM_WEIGHTS] <= wr_data_i;
               if (wr_slot_i == CNT_W'(2 * n + 1))
                  sht_q[n*THR_W +: THR_W] <= wr_data_i[THR_W-1:0];
            end
         end
      end
   end

   assign weights_o    = actw_q;
   assign thresholds_o = actt_q;

endmodule

// File: rtl/bnn_cfg_loader.sv
// Byte-serial frame receiver for the BNN core: sync, weight/threshold payload,
// XOR checksum, then an atomic commit of all neurons to the active config.
module bnn_cfg_loader
   import bnn_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               cfg_valid,
   input  logic [7:0]                         cfg_data,
   output logic                               cfg_ready,
   output logic [NUM_NEURONS*NUM_WEIGHTS-1:0] weights_flat,
   output logic [NUM_NEURONS*THR_W-1:0]       thresholds_flat,
   output logic                               cfg_done,
   output logic                               cfg_err,
   output logic                               busy
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   cfg_state_e       state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       acc_q, acc_d;
   logic [7:0]       csum_q;
   logic             fmt_bad_q;
   logic [TMO_W-1:0] tmo_q;

   logic accept;
   logic payload_done;
   logic wr_en;

   assign accept       = cfg_valid && cfg_ready;
   assign payload_done = (cnt_q == CNT_W'(PAYLOAD_BYTES));
   assign wr_en        = accept && (state_q == PAYLOAD) && !payload_done;
   assign cnt_d        = cnt_q + CNT_W'(1);
   assign acc_d        = acc_q ^ cfg_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         csum_q    <= '0;
         fmt_bad_q <= 1'b0;
         tmo_q     <= '0;
         cfg_ready <= 1'b1;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept && cfg_data == SYNC_BYTE) begin
                  state_q   <= PAYLOAD;
                  cnt_q     <= '0;
                  acc_q     <= '0;
                  fmt_bad_q <= 1'b0;
                  tmo_q     <= '0;
                  busy      <= 1'b1;
               end
            end
            PAYLOAD: begin
               if (accept) begin
                  tmo_q <= '0;
                  if (payload_done) begin
                     csum_q    <= cfg_data;
                     state_q   <= CHECK;
                     cfg_ready <= 1'b0;
                  end else begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_d;
                     if (!byte_fmt_ok(cfg_data, cnt_q[0]))
                        fmt_bad_q <= 1'b1;
                  end
               end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  // Stalled sender: drop the frame so the next sync byte is honoured.
                  state_q   <= IDLE;
                  tmo_q     <= '0;
                  fmt_bad_q <= 1'b0;
                  cfg_err   <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            CHECK: begin
               if (csum_q == acc_q && !fmt_bad_q) begin
                  state_q <= COMMIT;
               end else begin
                  state_q   <= IDLE;
                  cfg_err   <= 1'b1;
                  busy      <= 1'b0;
                  cfg_ready <= 1'b1;
               end
            end
            COMMIT: begin
               state_q   <= IDLE;
               cfg_done  <= 1'b1;
               busy      <= 1'b0;
               cfg_ready <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   bnn_cfg_shadow u_shadow (
      .clk          (clk),
      .reset        (reset),
      .wr_en_i      (wr_en),
      .wr_slot_i    (cnt_q),
      .wr_data_i    (cfg_data[NUM_WEIGHTS-1:0]),
      .commit_i     (state_q == COMMIT),
      .weights_o    (weights_flat),
      .thresholds_o (thresholds_flat)
   );

endmodule

// File: tb/tb_bnn_cfg_loader.sv
// Directed bench for bnn_cfg_loader: commit, checksum/format/timeout errors,
// reset mid-frame and junk bytes ahead of the sync byte.
module tb_bnn_cfg_loader;

   localparam int TMO = 255;

   localparam logic [23:0] W_DEF = 24'b110011_001100_000111_111000;
   localparam logic [11:0] T_DEF = 12'h492;

   // Frame A payload W0,T0,W1,T1,...; XOR of all eight bytes is 0x00.
   localparam logic [63:0] PAY_A  = 64'h3F05_0001_2A03_1507;
   localparam logic [23:0] W_A    = {6'h15, 6'h2A, 6'h00, 6'h3F};
   localparam logic [11:0] T_A    = {3'd7, 3'd3, 3'd1, 3'd5};
   // Same frame with W0=0x7F: reserved bit 6 set, XOR becomes 0x40.
   localparam logic [63:0] PAY_BAD = 64'h7F05_0001_2A03_1507;
   // Frame B: XOR = 0x0F.
   localparam logic [63:0] PAY_B  = 64'h0102_0204_0406_0800;
   localparam logic [23:0] W_B    = {6'h08, 6'h04, 6'h02, 6'h01};
   localparam logic [11:0] T_B    = {3'd0, 3'd6, 3'd4, 3'd2};

   logic        clk;
   logic        reset;
   logic        cfg_valid;
   logic [7:0]  cfg_data;
   logic        cfg_ready;
   logic [23:0] weights_flat;
   logic [11:0] thresholds_flat;
   logic        cfg_done;
   logic        cfg_err;
   logic        busy;

   int checks;
   int failures;

   bnn_cfg_loader dut (
      .clk             (clk),
      .reset           (reset),
      .cfg_valid       (cfg_valid),
      .cfg_data        (cfg_data),
      .cfg_ready       (cfg_ready),
      .weights_flat    (weights_flat),
      .thresholds_flat (thresholds_flat),
      .cfg_done        (cfg_done),
      .cfg_err         (cfg_err),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      cfg_valid = 1'b1;
      cfg_data  = b;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic send_payload(input logic [63:0] pay, input int nbytes);
      for (int i = 0; i < nbytes; i++)
         send_byte(pay[63 - 8*i -: 8]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends sync + full payload + checksum and checks the commit timing.
   task automatic frame_commit(input string tag, input logic [63:0] pay, input logic [7:0] cs,
                               input logic [23:0] ew, input logic [11:0] et);
      send_byte(8'hA5);
      send_payload(pay, 8);
      send_byte(cs);
      check({tag, "_ready_in_check"}, cfg_ready, 0);
      check({tag, "_busy_in_check"}, busy, 1);
      step();
      check({tag, "_done_early"}, cfg_done, 0);
      check({tag, "_w_not_yet"}, weights_flat, W_DEF);
      step();
      check({tag, "_done"}, cfg_done, 1);
      check({tag, "_err_with_done"}, cfg_err, 0);
      check({tag, "_w"}, weights_flat, ew);
      check({tag, "_t"}, thresholds_flat, et);
      step();
      check({tag, "_done_clear"}, cfg_done, 0);
      check({tag, "_ready_after"}, cfg_ready, 1);
   endtask

   // Sends a frame expected to be rejected at CHECK.
   task automatic frame_reject(input string tag, input logic [63:0] pay, input logic [7:0] cs);
      send_byte(8'hA5);
      send_payload(pay, 8);
      send_byte(cs);
      check({tag, "_err_early"}, cfg_err, 0);
      step();
      check({tag, "_err"}, cfg_err, 1);
      check({tag, "_no_done"}, cfg_done, 0);
      check({tag, "_busy"}, busy, 0);
      step();
      check({tag, "_no_late_done"}, cfg_done, 0);
      check({tag, "_w_kept"}, weights_flat, W_DEF);
      check({tag, "_t_kept"}, thresholds_flat, T_DEF);
   endtask

   initial begin
      logic got;
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_w", weights_flat, W_DEF);
      check("rst_t", thresholds_flat, T_DEF);
      check("rst_ready", cfg_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", cfg_done, 0);
      check("rst_err", cfg_err, 0);

      // Checksum 0x0A is wrong for frame A (true XOR is 0x00).
      frame_reject("bad_cs", PAY_A, 8'h0A);
      frame_reject("bad_fmt", PAY_BAD, 8'h40);

      // Stall mid-frame until the loader gives up.
      send_byte(8'hA5);
      send_payload(PAY_A, 3);
      check("tmo_busy_mid", busy, 1);
      got = 1'b0;
      for (int i = 0; i < TMO + 20 && !got; i++) begin
         step();
         if (cfg_err) got = 1'b1;
      end
      check("tmo_err", got, 1);
      check("tmo_busy", busy, 0);
      check("tmo_w_kept", weights_flat, W_DEF);

      frame_commit("frmB", PAY_B, 8'h0F, W_B, T_B);

      // Junk in IDLE is ignored.
      send_byte(8'h12);
      check("junk_busy", busy, 0);

      // Reset partway through a frame restores defaults.
      send_byte(8'hA5);
      send_payload(PAY_A, 5);
      check("mid_busy", busy, 1);
      reset = 1'b1;
      #2;
      check("midrst_w", weights_flat, W_DEF);
      check("midrst_t", thresholds_flat, T_DEF);
      check("midrst_busy", busy, 0);
      check("midrst_ready", cfg_ready, 1);
      step();
      reset = 1'b0;

      send_byte(8'h12);
      send_byte(8'h34);
      frame_commit("frmA", PAY_A, 8'h00, W_A, T_A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
